// File: rtl/controller_if.sv
// Control bundle between the multicycle controller and the 8-bit MIPS datapath:
// decoded instruction fields and ALU flag in, every datapath strobe out.
interface controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;

  logic       pcen;
  logic       iord;
  logic       memwrite;
  logic [3:0] irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucont;
  logic [1:0] pcsource;
  logic       illegal;
  logic       halted;

  modport master (
    input  op, funct, zero,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, alucont, pcsource, illegal, halted
  );

  modport slave (
    output op, funct, zero,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, alucont, pcsource, illegal, halted
  );
endinterface

// File: rtl/controller.sv
// Multicycle control FSM for the 8-bit MIPS core: byte-serial fetch, decode,
// then 1-3 execute states for LB, SB, R-type, BEQ, J and ADDI.
module controller #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input logic          clk,
  input logic          reset,
  controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, FETCH4, DECODE, MEMADR, LBRD, LBWR,
    SBWR, RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR, HALT
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic [3:0] irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucont;
    logic [1:0] pcsource;
    logic       illegal;
    logic       halted;
  } ctl_t;

  state_t state;
  ctl_t   ctl;
  ctl_t   ctl_out;
  logic   op_known;
  logic   funct_known;
  logic [2:0] rtype_alu;

  always_comb begin
    op_known = (bus.op == OP_LB) || (bus.op == OP_SB) || (bus.op == OP_RTYPE) ||
               (bus.op == OP_BEQ) || (bus.op == OP_J) || (bus.op == OP_ADDI);
  end

  // Unknown functs still complete as an add; only the flag reports them.
  always_comb begin
    funct_known = 1'b1;
    case (bus.funct)
      6'b100000: rtype_alu = ALU_ADD;
      6'b100010: rtype_alu = ALU_SUB;
      6'b100100: rtype_alu = ALU_AND;
      6'b100101: rtype_alu = ALU_OR;
      6'b101010: rtype_alu = ALU_SLT;
      default: begin
        rtype_alu   = ALU_ADD;
        funct_known = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // reader in this clock sees the pre-edge value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH1;
    end else begin
      case (state)
        FETCH1:  state <= FETCH2;
        FETCH2:  state <= FETCH3;
        FETCH3:  state <= FETCH4;
        FETCH4:  state <= DECODE;
        DECODE: begin
          case (bus.op)
            OP_LB, OP_SB: state <= MEMADR;
            OP_RTYPE:     state <= RTYPEEX;
            OP_BEQ:       state <= BEQEX;
            OP_J:         state <= JEX;
            OP_ADDI:      state <= ADDIEX;
            default:      state <= ILLEGAL_TRAP ? HALT : FETCH1;
          endcase
        end
        MEMADR:  state <= (bus.op == OP_SB) ? SBWR : LBRD;
        LBRD:    state <= LBWR;
        RTYPEEX: state <= RTYPEWR;
        ADDIEX:  state <= ADDIWR;
        HALT:    state <= HALT;
        default: state <= FETCH1;
      endcase
    end
  end

  // NOTE: every field gets a default before the case, so no latch is inferred.
  always_comb begin
    ctl         = '0;
    ctl.alucont = ALU_ADD;
    case (state)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        ctl.irwrite = 4'b1000 >> state[1:0];
        ctl.alusrcb = 2'b01;
        ctl.pcen    = 1'b1;
      end
      DECODE: begin
        ctl.alusrcb = 2'b11;
        ctl.illegal = ~op_known;
      end
      MEMADR, LBRD, LBWR, SBWR, ADDIEX, ADDIWR: begin
        // Address/write data come from the combinational ALU, so hold its setup.
        ctl.alusrca  = 1'b1;
        ctl.alusrcb  = 2'b10;
        ctl.iord     = (state == LBRD) || (state == SBWR);
        ctl.memwrite = (state == SBWR);
        ctl.memtoreg = (state == LBWR);
        ctl.regwrite = (state == LBWR) || (state == ADDIWR);
      end
      RTYPEEX, RTYPEWR: begin
        ctl.alusrca  = 1'b1;
        ctl.alucont  = rtype_alu;
        ctl.illegal  = (state == RTYPEEX) && !funct_known;
        ctl.regdst   = (state == RTYPEWR);
        ctl.regwrite = (state == RTYPEWR);
      end
      BEQEX: begin
        ctl.alusrca  = 1'b1;
        ctl.alucont  = ALU_SUB;
        ctl.pcsource = 2'b01;
        ctl.pcen     = bus.zero;
      end
      JEX: begin
        ctl.pcsource = 2'b10;
        ctl.pcen     = 1'b1;
      end
      HALT: begin
        ctl.alucont = 3'b000;
        ctl.halted  = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset blanks the strobes immediately, with no clock needed.
  assign ctl_out = reset ? '0 : ctl;

  assign bus.pcen     = ctl_out.pcen;
  assign bus.iord     = ctl_out.iord;
  assign bus.memwrite = ctl_out.memwrite;
  assign bus.irwrite  = ctl_out.irwrite;
  assign bus.regdst   = ctl_out.regdst;
  assign bus.memtoreg = ctl_out.memtoreg;
  assign bus.regwrite = ctl_out.regwrite;
  assign bus.alusrca  = ctl_out.alusrca;
  assign bus.alusrcb  = ctl_out.alusrcb;
  assign bus.alucont  = ctl_out.alucont;
  assign bus.pcsource = ctl_out.pcsource;
  assign bus.illegal  = ctl_out.illegal;
  assign bus.halted   = ctl_out.halted;

endmodule

// File: tb/tb_controller.sv
// Directed bench for the multicycle controller: both ILLEGAL_TRAP settings,
// every instruction class, illegal op/funct, and async reset mid-store.
module tb_controller;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  controller_if if0 ();
  controller_if if1 ();

  controller #(.ILLEGAL_TRAP(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0.master));
  controller #(.ILLEGAL_TRAP(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1.master));

  always #5 clk = ~clk;

  // Vector order: pcen iord memwrite irwrite regdst memtoreg regwrite
  //               alusrca alusrcb alucont pcsource illegal halted
  localparam logic [19:0] E_RST     = 20'b0_0_0_0000_0_0_0_0_00_000_00_0_0;
  localparam logic [19:0] E_F1      = 20'b1_0_0_1000_0_0_0_0_01_010_00_0_0;
  localparam logic [19:0] E_F2      = 20'b1_0_0_0100_0_0_0_0_01_010_00_0_0;
  localparam logic [19:0] E_F3      = 20'b1_0_0_0010_0_0_0_0_01_010_00_0_0;
  localparam logic [19:0] E_F4      = 20'b1_0_0_0001_0_0_0_0_01_010_00_0_0;
  localparam logic [19:0] E_DEC     = 20'b0_0_0_0000_0_0_0_0_11_010_00_0_0;
  localparam logic [19:0] E_DEC_ILL = 20'b0_0_0_0000_0_0_0_0_11_010_00_1_0;
  localparam logic [19:0] E_MEMADR  = 20'b0_0_0_0000_0_0_0_1_10_010_00_0_0;
  localparam logic [19:0] E_LBRD    = 20'b0_1_0_0000_0_0_0_1_10_010_00_0_0;
  localparam logic [19:0] E_LBWR    = 20'b0_0_0_0000_0_1_1_1_10_010_00_0_0;
  localparam logic [19:0] E_SBWR    = 20'b0_1_1_0000_0_0_0_1_10_010_00_0_0;
  localparam logic [19:0] E_ADDIEX  = 20'b0_0_0_0000_0_0_0_1_10_010_00_0_0;
  localparam logic [19:0] E_ADDIWR  = 20'b0_0_0_0000_0_0_1_1_10_010_00_0_0;
  localparam logic [19:0] E_JEX     = 20'b1_0_0_0000_0_0_0_0_00_010_10_0_0;
  localparam logic [19:0] E_HALT    = 20'b0_0_0_0000_0_0_0_0_00_000_00_0_1;

  function automatic logic [19:0] e_rtex(input logic [2:0] alu, input logic ill);
    return {3'b000, 4'b0000, 3'b000, 1'b1, 2'b00, alu, 2'b00, ill, 1'b0};
  endfunction

  function automatic logic [19:0] e_rtwr(input logic [2:0] alu);
    return {3'b000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, alu, 2'b00, 2'b00};
  endfunction

  function automatic logic [19:0] e_beq(input logic z);
    return {z, 6'b000000, 3'b000, 1'b1, 2'b00, 3'b110, 2'b01, 2'b00};
  endfunction

  function automatic logic [19:0] obs0();
    return {if0.pcen, if0.iord, if0.memwrite, if0.irwrite, if0.regdst, if0.memtoreg,
            if0.regwrite, if0.alusrca, if0.alusrcb, if0.alucont, if0.pcsource,
            if0.illegal, if0.halted};
  endfunction

  function automatic logic [19:0] obs1();
    return {if1.pcen, if1.iord, if1.memwrite, if1.irwrite, if1.regdst, if1.memtoreg,
            if1.regwrite, if1.alusrca, if1.alusrcb, if1.alucont, if1.pcsource,
            if1.illegal, if1.halted};
  endfunction

  task automatic check(input string tag, input logic [19:0] observed,
                       input logic [19:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Compare the selected DUT's strobes for this cycle, then advance one clock.
  task automatic step(input string tag, input bit sel, input logic [19:0] expected);
    check(tag, sel ? obs1() : obs0(), expected);
    @(negedge clk);
  endtask

  task automatic fetch(input string tag, input bit sel);
    step({tag, "_f1"}, sel, E_F1);
    step({tag, "_f2"}, sel, E_F2);
    step({tag, "_f3"}, sel, E_F3);
    step({tag, "_f4"}, sel, E_F4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] fn_tab  [6];
    logic [2:0] alu_tab [6];
    fn_tab  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    alu_tab = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b010};

    reset     = 1'b1;
    if0.op    = 6'b000000;
    if0.funct = 6'b100000;
    if0.zero  = 1'b0;
    if1.op    = 6'b000000;
    if1.funct = 6'b100000;
    if1.zero  = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", obs0(), E_RST);
    end
    reset = 1'b0;
    #1;

    // R-type: five legal functs, then an unknown one that still writes back
    for (int i = 0; i < 6; i++) begin
      if0.funct = fn_tab[i];
      fetch("rtype", 1'b0);
      step("rtype_dec", 1'b0, E_DEC);
      step("rtype_ex", 1'b0, e_rtex(alu_tab[i], i == 5));
      step("rtype_wr", 1'b0, e_rtwr(alu_tab[i]));
    end

    if0.op = 6'b100000;
    fetch("lb", 1'b0);
    step("lb_dec", 1'b0, E_DEC);
    step("lb_memadr", 1'b0, E_MEMADR);
    step("lb_rd", 1'b0, E_LBRD);
    step("lb_wr", 1'b0, E_LBWR);

    if0.op = 6'b101000;
    fetch("sb", 1'b0);
    step("sb_dec", 1'b0, E_DEC);
    step("sb_memadr", 1'b0, E_MEMADR);
    step("sb_wr", 1'b0, E_SBWR);

    if0.op   = 6'b000100;
    if0.zero = 1'b1;
    fetch("beq_taken", 1'b0);
    step("beq_taken_dec", 1'b0, E_DEC);
    step("beq_taken_ex", 1'b0, e_beq(1'b1));

    if0.zero = 1'b0;
    fetch("beq_not", 1'b0);
    step("beq_not_dec", 1'b0, E_DEC);
    step("beq_not_ex", 1'b0, e_beq(1'b0));

    if0.op = 6'b000010;
    fetch("j", 1'b0);
    step("j_dec", 1'b0, E_DEC);
    step("j_ex", 1'b0, E_JEX);

    if0.op = 6'b001000;
    fetch("addi", 1'b0);
    step("addi_dec", 1'b0, E_DEC);
    step("addi_ex", 1'b0, E_ADDIEX);
    step("addi_wr", 1'b0, E_ADDIWR);

    if0.op = 6'b111111;
    fetch("ill", 1'b0);
    step("ill_dec", 1'b0, E_DEC_ILL);

    // Next instruction's FETCH1 confirms the non-trapping return
    if0.op = 6'b101000;
    fetch("sb2", 1'b0);
    step("sb2_dec", 1'b0, E_DEC);
    step("sb2_memadr", 1'b0, E_MEMADR);
    check("sb2_wr", obs0(), E_SBWR);
    #2 reset = 1'b1;
    #1 check("async_reset_sbwr", obs0(), E_RST);
    @(negedge clk);
    reset = 1'b0;
    #1;
    step("post_reset_f1", 1'b0, E_F1);
    step("post_reset_f2", 1'b0, E_F2);

    // Trapping variant: unknown op parks the FSM until reset
    reset  = 1'b1;
    if1.op = 6'b111111;
    @(negedge clk);
    reset = 1'b0;
    #1;
    fetch("trap", 1'b1);
    step("trap_dec", 1'b1, E_DEC_ILL);
    for (int i = 0; i < 20; i++) step("trap_halt", 1'b1, E_HALT);
    reset = 1'b1;
    #1 check("trap_reset", obs1(), E_RST);
    @(negedge clk);
    reset  = 1'b0;
    if1.op = 6'b000000;
    #1;
    step("trap_recover_f1", 1'b1, E_F1);
    step("trap_recover_f2", 1'b1, E_F2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
